// File: rtl/opcode_sequencer_if.sv
// Program-load, control and breadboard-facing signals of the opcode sequencer.
interface opcode_sequencer_if #(
  parameter int AW = 4
);
  logic          LoadEn;
  logic [AW-1:0] LoadAddr;
  logic [20:0]   LoadData;
  logic          Start;
  logic          Abort;
  logic [1:0]    Error;
  logic [15:0]   InputA;
  logic [3:0]    OpCode;
  logic [AW-1:0] PC;
  logic          Busy;
  logic          Done;
  logic          Fault;
  logic [1:0]    FaultCode;
  logic [AW-1:0] FaultPC;

  modport master (
    output LoadEn, LoadAddr, LoadData, Start, Abort, Error,
    input  InputA, OpCode, PC, Busy, Done, Fault, FaultCode, FaultPC
  );

  modport slave (
    input  LoadEn, LoadAddr, LoadData, Start, Abort, Error,
    output InputA, OpCode, PC, Busy, Done, Fault, FaultCode, FaultPC
  );
endinterface

// File: rtl/opcode_sequencer.sv
// Stores a short {Last, OpCode, operand} program and issues one word per
// clock to the accumulator breadboard, halting on its first error.
// Outside RUN the outputs are held at NOP so the accumulator is untouched.
module opcode_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  opcode_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [15:0]   a_q, a_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [1:0]    fc_q, fc_d;
  logic [AW-1:0] fpc_q, fpc_d;

  logic [20:0]   mem [DEPTH];
  logic [20:0]   cur_word, nxt_word;
  logic [AW-1:0] pc_inc;

  assign pc_inc   = pc_q + AW'(1);
  assign cur_word = mem[pc_q];
  assign nxt_word = mem[pc_inc];

  // Program memory: loads only when no program is executing; never reset.
  always_ff @(posedge Clk) begin
    if (bus.LoadEn && state_q != RUN)
      mem[bus.LoadAddr] <= bus.LoadData;
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      pc_q    <= '0;
      fc_q    <= '0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      pc_q    <= pc_d;
      fc_q    <= fc_d;
      fpc_q   <= fpc_d;
    end
  end

  // Next state / next presented word; Abort > Error > end-of-program > advance.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    pc_d    = pc_q;
    fc_d    = fc_q;
    fpc_d   = fpc_q;
    case (state_q)
      RUN: begin
        if (bus.Abort) begin
          state_d = IDLE;
          op_d    = '0;
          a_d     = '0;
        end else if (bus.Error != 2'b00) begin
          state_d = FAULT;
          fc_d    = bus.Error;
          fpc_d   = pc_q;
          op_d    = '0;
          a_d     = '0;
        end else if (cur_word[20] || pc_q == AW'(DEPTH - 1)) begin
          // No wrap: a program without Last ends after DEPTH words.
          state_d = DONE;
          op_d    = '0;
          a_d     = '0;
        end else begin
          pc_d = pc_inc;
          op_d = nxt_word[19:16];
          a_d  = nxt_word[15:0];
        end
      end
      default: begin
        // Load takes priority over Start in the same cycle.
        if (bus.Start && !bus.LoadEn) begin
          state_d = RUN;
          pc_d    = '0;
          op_d    = mem[0][19:16];
          a_d     = mem[0][15:0];
          fc_d    = '0;
          fpc_d   = '0;
        end
      end
    endcase
  end

  assign bus.OpCode    = op_q;
  assign bus.InputA    = a_q;
  assign bus.PC        = pc_q;
  assign bus.Busy      = (state_q == RUN);
  assign bus.Done      = (state_q == DONE);
  assign bus.Fault     = (state_q == FAULT);
  assign bus.FaultCode = fc_q;
  assign bus.FaultPC   = fpc_q;
endmodule

// File: doc/opcode_sequencer.md
Name: opcode_sequencer

Overview:
- Upstream stage of the 16-bit accumulator breadboard. Stores a short program of {OpCode, operand} words and issues one word per Clk to the breadboard's OpCode/InputA inputs.
- Monitors the breadboard's 2-bit Error bus and halts on the first error.
- Drives OpCode 4'b0000 (hold accumulator) whenever it is not running, so the accumulator is never disturbed while idle.

Parameters:
- DEPTH, 16, number of program words (power of two, 2..256).
- AW, 4, address width, log2(DEPTH).

Ports:
- Clk, in, 1, system clock; all state updates on rising edge.
- Reset, in, 1, synchronous, active-high reset.
- LoadEn, in, 1, write LoadData into program memory at LoadAddr.
- LoadAddr, in, AW, program write address.
- LoadData, in, 21, program word: bit20=Last, bits19:16=OpCode, bits15:0=operand.
- Start, in, 1, single-cycle pulse; begins execution at address 0.
- Abort, in, 1, stops a running program.
- Error, in, 2, breadboard Error bus: bit0=add/sub overflow, bit1=divide/modulus by zero.
- InputA, out, 16, registered operand to the breadboard.
- OpCode, out, 4, registered opcode to the breadboard.
- PC, out, AW, address of the word currently presented.
- Busy, out, 1, high in RUN.
- Done, out, 1, high in DONE.
- Fault, out, 1, high in FAULT.
- FaultCode, out, 2, Error value captured at the fault.
- FaultPC, out, AW, PC of the faulting word.

Behaviour:
- Clocking and reset: one clock (Clk). Reset is synchronous and active-high.
- Reset values: state=IDLE, OpCode=0000, InputA=0, PC=0, FaultCode=0, FaultPC=0, Busy=Done=Fault=0.
- Reset does not clear program memory. Reset mid-RUN gives IDLE with NOP on the next cycle; no Done or Fault is reported.
- Memory: DEPTH x 21 register array, combinational read at PC or PC+1.
  - Writes are accepted only in IDLE, DONE or FAULT. LoadEn in RUN is ignored.
- States: IDLE, RUN, DONE, FAULT. Outputs are NOP (0000/0) in every state except RUN.
- IDLE, DONE or FAULT:
  - LoadEn high: write the word; Start is ignored that cycle (load has priority).
  - Start high, LoadEn low: go to RUN; PC<=0; OpCode/InputA<=mem[0] fields; FaultCode and FaultPC cleared.
- RUN, word at PC presented. On each edge, evaluate in this priority order:
  1. Abort: go to IDLE; outputs NOP. The breadboard still commits the word presented that cycle.
  2. Error!=0: go to FAULT; FaultCode<=Error; FaultPC<=PC; outputs NOP. The breadboard commits the faulting result at the same edge; the sequencer does not undo it.
  3. mem[PC].Last=1 or PC==DEPTH-1: go to DONE; outputs NOP. A program without a Last bit therefore ends after DEPTH words (no wrap to 0).
  4. Otherwise: PC<=PC+1; outputs <= mem[PC+1].
- Latency:
  - Start edge to first word on outputs: 1 cycle.
  - A program of N words occupies N RUN cycles, and Done rises on the edge after word N-1 is presented.
- Start in RUN is ignored. Start and Abort together in IDLE: Start wins (Abort is meaningful only in RUN).
- Error is sampled only in RUN. Error while idle is ignored; it cannot occur anyway because NOP never flags errors.

Test Plan:
1. Circumference program. Load [0001/0, 0100/2, 0110/5, 0110/314, 0111/100 Last]; pulse Start. -> OpCodes 1,4,6,6,7 on five consecutive cycles; Result=31 after the last edge; Done=1 and OpCode=0000 the following cycle; Busy high exactly 5 cycles.
2. Divide-by-zero. Load [0001/0, 0100/7, 0111/0, 0100/1 Last]; Start. -> Fault=1, FaultCode=2'b10, FaultPC=2; word 3 never issued; OpCode=0000 thereafter.
3. Overflow. Load [0010/0 (preset), 0100/16'h7FFF Last]; Start. -> Error[0] detected; Fault=1, FaultCode=2'b01, FaultPC=1.
4. Abort and Reset mid-run. Assert Abort with PC=2 of a 6-word program. -> IDLE next cycle, Done=0, Fault=0, NOP output. Repeat using Reset instead of Abort. -> same, and a subsequent Start replays the unchanged memory from address 0.
5. No Last bit (DEPTH=16). Fill all 16 words with 0100/1; Start after a Reset opcode. -> 16 issue cycles, PC peaks at 15, Done=1, accumulator=16.
6. Priority and ignore checks. LoadEn+Start in the same IDLE cycle -> word written, state stays IDLE. LoadEn during RUN -> memory unchanged. Start during RUN -> no restart.
